// File: rtl/cp0_exc_ctrl_pkg.sv
// CP0 exception controller shared definitions: Status/Cause field positions,
// ExcCode values, default exception vector and the sequencer state type.
package cp0_pkg;

  localparam int unsigned IE_BIT  = 0;
  localparam int unsigned EXL_BIT = 1;
  localparam int unsigned IM_HI   = 15;
  localparam int unsigned IM_LO   = 8;
  localparam int unsigned IP_HI   = 15;
  localparam int unsigned IP_LO   = 8;
  localparam int unsigned EXC_HI  = 6;
  localparam int unsigned EXC_LO  = 2;
  localparam int unsigned BD_BIT  = 31;

  localparam int unsigned EXC_W = 5;
  typedef logic [EXC_W-1:0] exc_code_t;

  localparam exc_code_t EXC_INT  = 5'd0;
  localparam exc_code_t EXC_ADEL = 5'd4;
  localparam exc_code_t EXC_SYS  = 5'd8;
  localparam exc_code_t EXC_RI   = 5'd10;
  localparam exc_code_t EXC_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0180;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } cp0_state_e;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// MEM-stage commit interface between the pipeline (master) and the CP0
// exception controller (slave): instruction status in, flush/redirect out.
interface cp0_exc_ctrl_if;
  import cp0_pkg::*;

  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic        exc_valid;
  exc_code_t   exc_code;
  logic        eret;
  logic        mem_stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output mem_valid, mem_pc, mem_bd, exc_valid, exc_code, eret, mem_stall,
    input  flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_valid, mem_pc, mem_bd, exc_valid, exc_code, eret, mem_stall,
    output flush, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/cp0_exc_ctrl_int_sync.sv
// Two-flop synchroniser for the asynchronous hardware interrupt lines.
module cp0_int_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= '0;
      sync_out <= '0;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the MEM commit point: owns Cause/EPC,
// sequences commit -> flush -> redirect. Optional CP0_TIMER_EN adds Count/Compare.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] RST_CAUSE  = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   status_q,
  output logic [31:0]   status_d,
  input  logic [5:0]    hw_int,
  cp0_exc_ctrl_if.slave pipe,
  input  logic          cause_we,
  input  logic [31:0]   cause_wdata,
  input  logic          compare_we,
  input  logic [31:0]   compare_wdata,
  output logic [31:0]   cause_q,
  output logic [31:0]   epc_q
);

  logic [5:0]  hw_sync;
  logic        ip7;
  logic [7:0]  ip;
  logic        bd_q;
  logic [1:0]  sw_ip_q;
  exc_code_t   exc_code_q;
  logic [31:0] target_q;
  logic        int_req;
  logic        commit_exc;
  logic        commit_eret;
  cp0_state_e  state_q, state_d;

  cp0_int_sync #(.WIDTH(6)) u_int_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (hw_int),
    .sync_out (hw_sync)
  );

`ifdef CP0_TIMER_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_pend_q;
  logic        unused_hw5;

  // Timer pending takes the IP7 slot; a Compare write both reloads and acknowledges.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      compare_q    <= '1;
      timer_pend_q <= 1'b0;
    end else begin
      count_q <= count_q + 32'd1;
      if (compare_we) begin
        compare_q    <= compare_wdata;
        timer_pend_q <= 1'b0;
      end else if (count_q == compare_q) begin
        timer_pend_q <= 1'b1;
      end
    end
  end

  assign ip7        = timer_pend_q;
  assign unused_hw5 = hw_sync[5];
`else
  logic unused_timer;
  assign ip7          = hw_sync[5];
  assign unused_timer = ^{compare_we, compare_wdata};
`endif

  logic unused_cause_wdata;
  assign unused_cause_wdata = ^{cause_wdata[31:IP_LO+2], cause_wdata[IP_LO-1:0]};

  assign ip = {ip7, hw_sync[4:0], sw_ip_q};

  always_comb begin
    cause_q                 = '0;
    cause_q[BD_BIT]         = bd_q;
    cause_q[IP_HI:IP_LO]    = ip;
    cause_q[EXC_HI:EXC_LO]  = exc_code_q;
  end

  assign int_req = status_q[IE_BIT] & ~status_q[EXL_BIT]
                 & (|(ip & status_q[IM_HI:IM_LO])) & pipe.mem_valid;

  // Priority: interrupt > synchronous exception > eret; nothing commits while stalled.
  assign commit_exc  = (state_q == ST_IDLE) & ~pipe.mem_stall & (int_req | pipe.exc_valid);
  assign commit_eret = (state_q == ST_IDLE) & ~pipe.mem_stall & ~int_req & ~pipe.exc_valid
                     & pipe.eret;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (commit_exc | commit_eret) state_d = ST_FLUSH;
      ST_FLUSH:    state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default first, so no path through this block infers a latch.
  always_comb begin
    status_d            = status_q;
    pipe.flush          = 1'b0;
    pipe.redirect_valid = 1'b0;
    pipe.redirect_pc    = '0;
    case (state_q)
      ST_IDLE: begin
        if (commit_exc)       status_d[EXL_BIT] = 1'b1;
        else if (commit_eret) status_d[EXL_BIT] = 1'b0;
      end
      ST_FLUSH:    pipe.flush = 1'b1;
      ST_REDIRECT: begin
        pipe.flush          = 1'b1;
        pipe.redirect_valid = 1'b1;
        pipe.redirect_pc    = target_q;
      end
      default: ;
    endcase
  end

  // Software IP bits and the hardware BD/ExcCode fields are disjoint, so both may update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q      <= '0;
      bd_q       <= RST_CAUSE[BD_BIT];
      sw_ip_q    <= RST_CAUSE[IP_LO+1:IP_LO];
      exc_code_q <= RST_CAUSE[EXC_HI:EXC_LO];
      target_q   <= '0;
    end else begin
      if (cause_we) sw_ip_q <= cause_wdata[IP_LO+1:IP_LO];
      if (commit_exc) begin
        epc_q      <= pipe.mem_bd ? (pipe.mem_pc - 32'd4) : pipe.mem_pc;
        bd_q       <= pipe.mem_bd;
        exc_code_q <= int_req ? EXC_INT : pipe.exc_code;
        target_q   <= EXC_VECTOR;
      end else if (commit_eret) begin
        target_q   <= epc_q;
      end
    end
  end

endmodule
